framed_word_loopback_tx: RTL and testbench

Parametrised word transmitter with return-path checking. It splits a WORD_W-bit word into bytes, MSB byte first, and frames each byte as 9 bits: data in [8:1], parity in [0]. Each frame goes out over a valid/ack handshake with a programmable inter-byte gap. It then collects the same number of framed bytes back on the return channel, checks parity, reassembles the word and compares it with the word sent. It sits between the host word source and the UART/SPI-style byte receiver, as the self-checking loopback endpoint.

---
 rtl/framed_word_loopback_tx_if.sv | 27 ++
 rtl/framed_word_loopback_tx.sv | 191 +++++++++++++++++++
 tb/tb_framed_word_loopback_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/framed_word_loopback_tx_if.sv
// Framed byte channels between the loopback transmitter and the byte receiver.
// The forward path carries tx_* frames. The return path carries rx_* frames.
interface framed_word_loopback_tx_if #(
  parameter int WORD_W = 32
);
  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic             tx_valid;
  logic [8:0]       tx_data;
  logic             tx_ack;
  logic [IDX_W-1:0] tx_idx;
  logic             rx_valid;
  logic [8:0]       rx_data;
  logic             rx_ack;
  logic [IDX_W-1:0] rx_idx;

  modport master (
    output tx_valid, tx_data, tx_idx, rx_ack, rx_idx,
    input  tx_ack, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_idx, rx_ack, rx_idx,
    output tx_ack, rx_valid, rx_data
  );
endinterface

// File: rtl/framed_word_loopback_tx.sv
// Word transmitter with return-path checking. The word is sent as 9-bit frames,
// {byte, parity}, MSB byte first. The same number of frames is then collected
// back, parity-checked, reassembled into a word and compared with the word sent.
module framed_word_loopback_tx #(
  parameter int WORD_W     = 32,
  parameter int PARITY_ODD = 0,
  parameter int GAP        = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       b,
  input  logic                       start,
  input  logic [WORD_W-1:0]          in,
  output logic                       busy,
  framed_word_loopback_tx_if.master  lb,
  output logic [WORD_W-1:0]          received_data,
  output logic                       done,
  output logic                       match,
  output logic                       parity_err,
  output logic                       timeout
);
  localparam int   NB    = WORD_W / 8;
  localparam int   IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int   GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int   TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int   SH_W  = $clog2(WORD_W);
  localparam logic P_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_SEND,
    S_TX_GAP,
    S_RX_WAIT,
    S_DONE
  } state_t;

  state_t             r_state, w_state_n;
  logic [WORD_W-1:0]  r_shadow, w_shadow_n;
  logic [WORD_W-1:0]  r_received, w_received_n;
  logic [IDX_W-1:0]   r_tx_idx, w_tx_idx_n;
  logic [IDX_W-1:0]   r_rx_idx, w_rx_idx_n;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_n;
  logic [TO_W-1:0]    r_to_cnt, w_to_cnt_n;
  logic               r_parity_err, w_parity_err_n;
  logic               r_timeout, w_timeout_n;
  logic               r_match, w_match_n;
  logic               w_rx_ack;
  logic               w_to_hit;
  logic [SH_W-1:0]    w_tx_sh, w_rx_sh;
  logic [7:0]         w_tx_byte;
  logic [WORD_W-1:0]  w_rx_merge;

  function automatic logic f_parity(input logic [7:0] d);
    return (^d) ^ P_ODD;
  endfunction

  // Byte lanes: index 0 is the most significant byte of the word.
  assign w_tx_sh    = SH_W'(8 * (NB - 1 - int'(r_tx_idx)));
  assign w_rx_sh    = SH_W'(8 * (NB - 1 - int'(r_rx_idx)));
  assign w_tx_byte  = 8'(r_shadow >> w_tx_sh);
  assign w_rx_merge = (r_received & ~(WORD_W'(8'hFF) << w_rx_sh))
                    | (WORD_W'(lb.rx_data[8:1]) << w_rx_sh);
  assign w_to_hit   = (TIMEOUT != 0) && (int'(r_to_cnt) == TIMEOUT - 1);

  // State register and per-transaction datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_received   <= '0;
      r_tx_idx     <= '0;
      r_rx_idx     <= '0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
      r_parity_err <= 1'b0;
      r_timeout    <= 1'b0;
      r_match      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_shadow     <= w_shadow_n;
      r_received   <= w_received_n;
      r_tx_idx     <= w_tx_idx_n;
      r_rx_idx     <= w_rx_idx_n;
      r_gap_cnt    <= w_gap_cnt_n;
      r_to_cnt     <= w_to_cnt_n;
      r_parity_err <= w_parity_err_n;
      r_timeout    <= w_timeout_n;
      r_match      <= w_match_n;
    end
  end

  // Next-state and datapath updates. The wait counter defaults to zero, so it
  // clears on every state change and on every accepted handshake.
  always_comb begin
    w_state_n      = r_state;
    w_shadow_n     = r_shadow;
    w_received_n   = r_received;
    w_tx_idx_n     = r_tx_idx;
    w_rx_idx_n     = r_rx_idx;
    w_gap_cnt_n    = r_gap_cnt;
    w_to_cnt_n     = '0;
    w_parity_err_n = r_parity_err;
    w_timeout_n    = r_timeout;
    w_match_n      = r_match;
    w_rx_ack       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shadow_n     = in;
          w_received_n   = '0;
          w_parity_err_n = 1'b0;
          w_timeout_n    = 1'b0;
          w_match_n      = 1'b0;
          w_tx_idx_n     = '0;
          w_rx_idx_n     = '0;
          w_state_n      = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        // An ack in the terminal-count cycle takes priority over the abort.
        if (lb.tx_ack) begin
          if (int'(r_tx_idx) == NB - 1) begin
            w_rx_idx_n = '0;
            w_state_n  = S_RX_WAIT;
          end else begin
            w_tx_idx_n  = r_tx_idx + 1'b1;
            w_gap_cnt_n = '0;
            w_state_n   = S_TX_GAP;
          end
        end else if (w_to_hit) begin
          w_timeout_n = 1'b1;
          w_match_n   = 1'b0;
          w_state_n   = S_DONE;
        end else begin
          w_to_cnt_n = r_to_cnt + 1'b1;
        end
      end
      S_TX_GAP: begin
        if (GAP == 0) begin
          w_state_n = S_TX_SEND;
        end else if (b) begin
          if (int'(r_gap_cnt) == GAP - 1) begin
            w_state_n = S_TX_SEND;
          end else begin
            w_gap_cnt_n = r_gap_cnt + 1'b1;
          end
        end
      end
      S_RX_WAIT: begin
        if (lb.rx_valid) begin
          w_rx_ack       = 1'b1;
          w_parity_err_n = r_parity_err
                         | (f_parity(lb.rx_data[8:1]) != lb.rx_data[0]);
          w_received_n   = w_rx_merge;
          if (int'(r_rx_idx) == NB - 1) begin
            // Decided on the incoming values so match is valid alongside done.
            w_match_n = !w_parity_err_n && !r_timeout && (w_rx_merge == r_shadow);
            w_state_n = S_DONE;
          end else begin
            w_rx_idx_n = r_rx_idx + 1'b1;
          end
        end else if (w_to_hit) begin
          w_timeout_n = 1'b1;
          w_match_n   = 1'b0;
          w_state_n   = S_DONE;
        end else begin
          w_to_cnt_n = r_to_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign lb.tx_valid    = (r_state == S_TX_SEND);
  assign lb.tx_data     = lb.tx_valid ? {w_tx_byte, f_parity(w_tx_byte)} : '0;
  assign lb.tx_idx      = r_tx_idx;
  assign lb.rx_ack      = w_rx_ack;
  assign lb.rx_idx      = r_rx_idx;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign received_data  = r_received;
  assign match          = r_match;
  assign parity_err     = r_parity_err;
  assign timeout        = r_timeout;
endmodule

// File: tb/tb_framed_word_loopback_tx.sv
// Bench for framed_word_loopback_tx. Two instances: a 32-bit even-parity unit
// with gap and timeout, and a 16-bit odd-parity unit with no gap. Expected frames
// go into a queue when start is driven and are compared as the DUT offers them.
// Accepted frames are looped back on the return channel.
module tb_framed_word_loopback_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, b;
  int   n_total = 0;
  int   n_bad   = 0;

  // Shared stimulus, routed to the selected DUT.
  logic        sel;
  logic        d_start, d_tx_ack, d_rx_valid;
  logic [31:0] d_in;
  logic [8:0]  d_rx_data;

  logic        a_start, a_busy, a_done, a_match, a_perr, a_to;
  logic [31:0] a_in, a_rxd;
  logic        b_start, b_busy, b_done, b_match, b_perr, b_to;
  logic [15:0] b_in, b_rxd;

  framed_word_loopback_tx_if #(.WORD_W(32)) a_if ();
  framed_word_loopback_tx_if #(.WORD_W(16)) b_if ();

  framed_word_loopback_tx #(.WORD_W(32), .PARITY_ODD(0), .GAP(4), .TIMEOUT(10)) dut_a (
    .clk(clk), .rst(rst), .b(b), .start(a_start), .in(a_in), .busy(a_busy),
    .lb(a_if.master), .received_data(a_rxd), .done(a_done), .match(a_match),
    .parity_err(a_perr), .timeout(a_to)
  );

  framed_word_loopback_tx #(.WORD_W(16), .PARITY_ODD(1), .GAP(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .b(b), .start(b_start), .in(b_in), .busy(b_busy),
    .lb(b_if.master), .received_data(b_rxd), .done(b_done), .match(b_match),
    .parity_err(b_perr), .timeout(b_to)
  );

  assign a_start        = d_start & !sel;
  assign b_start        = d_start & sel;
  assign a_in           = d_in;
  assign b_in           = d_in[15:0];
  assign a_if.tx_ack    = d_tx_ack & !sel;
  assign b_if.tx_ack    = d_tx_ack & sel;
  assign a_if.rx_valid  = d_rx_valid & !sel;
  assign b_if.rx_valid  = d_rx_valid & sel;
  assign a_if.rx_data   = d_rx_data;
  assign b_if.rx_data   = d_rx_data;

  logic        m_tx_valid, m_rx_ack, m_busy, m_done, m_match, m_perr, m_to;
  logic [8:0]  m_tx_data;
  logic [1:0]  m_tx_idx, m_rx_idx;
  logic [31:0] m_rxd;

  always_comb begin
    if (sel) begin
      m_tx_valid = b_if.tx_valid;  m_tx_data = b_if.tx_data;
      m_tx_idx   = {1'b0, b_if.tx_idx};  m_rx_idx = {1'b0, b_if.rx_idx};
      m_rx_ack   = b_if.rx_ack;    m_busy = b_busy;  m_done = b_done;
      m_match    = b_match;  m_perr = b_perr;  m_to = b_to;  m_rxd = {16'h0, b_rxd};
    end else begin
      m_tx_valid = a_if.tx_valid;  m_tx_data = a_if.tx_data;
      m_tx_idx   = a_if.tx_idx;    m_rx_idx = a_if.rx_idx;
      m_rx_ack   = a_if.rx_ack;    m_busy = a_busy;  m_done = a_done;
      m_match    = a_match;  m_perr = a_perr;  m_to = a_to;  m_rxd = a_rxd;
    end
  end

  // b tick on every third clock.
  initial begin
    int unsigned bc;
    bc = 0;
    b  = 1'b0;
    forever begin
      @(negedge clk);
      bc++;
      b = (bc % 3 == 0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_txv"}, m_tx_valid, 0);
    chk({tag, "_txd"}, m_tx_data, 0);
    chk({tag, "_txidx"}, m_tx_idx, 0);
    chk({tag, "_rxidx"}, m_rx_idx, 0);
    chk({tag, "_rxack"}, m_rx_ack, 0);
    chk({tag, "_rxd"}, m_rxd, 0);
    chk({tag, "_flags"}, {m_done, m_match, m_perr, m_to}, 0);
  endtask

  // One transaction: start, scoreboard the frames, loop them back, check the result.
  task automatic run_txn(input logic s, input logic [31:0] word, input int nb,
                         input logic odd, input int ack_delay, input logic noack,
                         input int corrupt_idx, input int rst_after,
                         input logic busy_start, input logic gap_chk);
    logic [8:0]  exp_q[$];
    logic [8:0]  ret_q[$];
    logic [8:0]  first, fr;
    logic [7:0]  byt;
    logic [31:0] exp_rxd;
    logic        fin, gapm;
    int          held, nsent, nrx, bt, txc, ndone;
    fin = 0; gapm = 0; held = 0; nsent = 0; nrx = 0; bt = 0; txc = 0; first = '0;
    exp_rxd = noack ? 32'h0 : word;
    sel = s;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      byt = 8'(word >> (8 * (nb - 1 - i)));
      exp_q.push_back({byt, (^byt) ^ odd});
    end
    d_in = word;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    chk("busy_rise", m_busy, 1);
    chk("txv_rise", m_tx_valid, 1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (m_done) begin
        chk("rxd", m_rxd, exp_rxd);
        chk("match", m_match, (!noack && corrupt_idx < 0));
        chk("perr", m_perr, (corrupt_idx >= 0));
        chk("timeout", m_to, noack);
        chk("txv_at_done", m_tx_valid, 0);
        if (noack) chk("to_cycles", txc, 10);
        else       chk("rx_count", nrx, nb);
        d_tx_ack = 1'b0;
        d_rx_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", m_done, 0);
        chk("busy_fall", m_busy, 0);
        chk("rxd_hold", m_rxd, exp_rxd);
        chk("perr_hold", m_perr, (corrupt_idx >= 0));
        fin = 1;
      end else begin
        d_tx_ack = 1'b0;
        if (m_tx_valid) begin
          if (gapm) begin
            if (gap_chk) chk("gap_ticks", bt, 4);
            gapm = 0;
          end
          txc++;
          if (held == 0) first = m_tx_data;
          else chk("tx_stable", m_tx_data, first);
          if (!noack && held >= ack_delay) begin
            if (exp_q.size() == 0) begin
              chk("tx_extra", 1, 0);
            end else begin
              chk("tx_data", m_tx_data, exp_q[0]);
              chk("tx_idx", m_tx_idx, nsent);
              fr = exp_q.pop_front();
              if (nsent == corrupt_idx) fr = fr ^ 9'h001;
              ret_q.push_back(fr);
            end
            nsent++;
            d_tx_ack = 1'b1;
            held = 0;
            if (nsent < nb) begin
              gapm = 1;
              bt = 0;
            end
          end else begin
            held++;
          end
        end
        d_rx_valid = (ret_q.size() > 0);
        d_rx_data  = d_rx_valid ? ret_q[0] : 9'h0;
        d_start    = busy_start && (cyc == 2);
        d_in       = (busy_start && cyc == 2) ? ~word : word;
        #1;
        if (gapm && !m_tx_valid && b) bt++;
        if (m_rx_ack) begin
          chk("rx_idx", m_rx_idx, nrx);
          void'(ret_q.pop_front());
          nrx++;
          if (nrx == rst_after) begin
            @(negedge clk);
            chk("pre_rst_idx", m_rx_idx, rst_after);
            #2;
            rst = 1'b0;
            #1;
            chk_all_zero("async_rst");
            d_rx_valid = 1'b0;
            d_tx_ack = 1'b0;
            ndone = 0;
            repeat (2) begin
              @(negedge clk);
              if (m_done) ndone++;
            end
            rst = 1'b1;
            repeat (4) begin
              @(negedge clk);
              if (m_done) ndone++;
            end
            chk("no_done_after_rst", ndone, 0);
            fin = 1;
          end
        end
        if (!fin) @(negedge clk);
      end
    end
    if (!fin) chk("cycle_budget", 0, 1);
    d_start = 1'b0;
    d_tx_ack = 1'b0;
    d_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0;
    d_start = 1'b0; d_in = '0; d_tx_ack = 1'b0; d_rx_valid = 1'b0; d_rx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset_a");
    sel = 1'b1;
    #1;
    chk_all_zero("reset_b");
    rst = 1'b1;
    // sel, word, nb, odd, ack_delay, noack, corrupt_idx, rst_after, busy_start, gap_chk
    run_txn(1'b0, 32'hA5C30F01, 4, 1'b0, 0, 1'b0, -1, -1, 1'b0, 1'b1);
    run_txn(1'b0, 32'hA5C30F01, 4, 1'b0, 0, 1'b0,  1, -1, 1'b0, 1'b1);
    run_txn(1'b0, 32'h5A3CF0E7, 4, 1'b0, 5, 1'b0, -1, -1, 1'b0, 1'b1);
    run_txn(1'b0, 32'hDEADBEEF, 4, 1'b0, 0, 1'b1, -1, -1, 1'b0, 1'b0);
    run_txn(1'b0, 32'hCAFEF00D, 4, 1'b0, 0, 1'b0, -1,  2, 1'b0, 1'b1);
    run_txn(1'b0, 32'h12345678, 4, 1'b0, 0, 1'b0, -1, -1, 1'b0, 1'b1);
    run_txn(1'b1, 32'h000000FF, 2, 1'b1, 0, 1'b0, -1, -1, 1'b1, 1'b0);
    run_txn(1'b1, 32'h00008E31, 2, 1'b1, 2, 1'b0,  0, -1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
